// File: rtl/ghr_pkg.sv
// Shared types and sizing for the speculative global-history controller.
// Supplies a fallback NUM_PERCEPTRONS when the build does not define one.
`ifndef NUM_PERCEPTRONS
`define NUM_PERCEPTRONS 16
`endif

package ghr_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      RECOVER = 1'b1
   } ghr_state_t;

   localparam int GHR_MAX_INFLIGHT = 8;
   localparam int PERF_CNT_W       = 32;

   // Counter must be able to hold MAX_INFLIGHT itself, not just MAX_INFLIGHT-1.
   function automatic int inflight_width(input int max_inflight);
      return $clog2(max_inflight + 1);
   endfunction

   localparam int INFLIGHT_W = inflight_width(GHR_MAX_INFLIGHT);

endpackage

// File: rtl/ghr_perf_counters.sv
// Free-running mispredict and stall event counters, 32-bit wrapping.
// Instantiated by ghr_controller only when GHR_CTRL_PERF_EN is defined.
module ghr_perf_counters
   import ghr_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mispredict_i,
   input  logic                  stall_i,
   output logic [PERF_CNT_W-1:0] mispredict_cnt,
   output logic [PERF_CNT_W-1:0] stall_cnt
);

   logic [PERF_CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;
   logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      mispredict_cnt_d = mispredict_cnt_q;
      stall_cnt_d      = stall_cnt_q;
      if (mispredict_i) mispredict_cnt_d = mispredict_cnt_q + PERF_CNT_W'(1);
      if (stall_i)      stall_cnt_d      = stall_cnt_q + PERF_CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mispredict_cnt_q <= '0;
         stall_cnt_q      <= '0;
      end else begin
         mispredict_cnt_q <= mispredict_cnt_d;
         stall_cnt_q      <= stall_cnt_d;
      end
   end

   assign mispredict_cnt = mispredict_cnt_q;
   assign stall_cnt      = stall_cnt_q;

endmodule

// File: rtl/ghr_controller.sv
// Speculative/architectural global-history manager with in-flight throttling
// and one-cycle mispredict recovery. Optional perf counters: GHR_CTRL_PERF_EN.
`ifndef NUM_PERCEPTRONS
`define NUM_PERCEPTRONS 16
`endif

module ghr_controller
   import ghr_pkg::*;
#(
   parameter  int N            = `NUM_PERCEPTRONS,
   parameter  int MAX_INFLIGHT = GHR_MAX_INFLIGHT,
   localparam int IW           = inflight_width(MAX_INFLIGHT)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pred_valid,
   input  logic                  pred_taken,
   output logic                  pred_ready,
   input  logic                  res_valid,
   input  logic                  res_taken,
   input  logic                  res_mispredict,
   output logic [N-1:0]          spec_hist,
   output logic [N-1:0]          arch_hist,
   output logic [IW-1:0]         inflight,
   output logic                  recovering,
   output logic                  underflow_err
`ifdef GHR_CTRL_PERF_EN
   ,
   output logic [PERF_CNT_W-1:0] mispredict_cnt,
   output logic [PERF_CNT_W-1:0] stall_cnt
`endif
);

   localparam logic [IW-1:0] MAX_CNT = IW'(MAX_INFLIGHT);

   ghr_state_t    state_q, state_d;
   logic [N-1:0]  spec_q, spec_d;
   logic [N-1:0]  arch_q, arch_d;
   logic [IW-1:0] inflight_q, inflight_d;
   logic          ready_q, ready_d;
   logic          recovering_q, recovering_d;
   logic          underflow_q, underflow_d;

   logic          accept;
   logic          res_ok;
   logic          mispredict;
   logic [N-1:0]  arch_shifted;

   assign accept       = pred_valid && ready_q;
   assign res_ok       = res_valid && (inflight_q != '0);
   assign mispredict   = res_ok && res_mispredict;
   assign arch_shifted = {arch_q[N-2:0], res_taken};

   always_comb begin
      state_d     = RUN;
      spec_d      = spec_q;
      arch_d      = arch_q;
      inflight_d  = inflight_q;
      underflow_d = underflow_q | (res_valid && (inflight_q == '0));
      if (mispredict) begin
         // Squash everything younger; a same-cycle prediction is dropped.
         arch_d     = arch_shifted;
         spec_d     = arch_shifted;
         inflight_d = '0;
         state_d    = RECOVER;
      end else begin
         if (res_ok) arch_d = arch_shifted;
         if (accept) spec_d = {spec_q[N-2:0], pred_taken};
         inflight_d = inflight_q + IW'(accept) - IW'(res_ok);
      end
      // Ready and recovering are decoded from next state so they leave a flop.
      ready_d      = (state_d == RUN) && (inflight_d < MAX_CNT);
      recovering_d = (state_d == RECOVER);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= RUN;
         spec_q       <= '0;
         arch_q       <= '0;
         inflight_q   <= '0;
         ready_q      <= 1'b1;
         recovering_q <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         spec_q       <= spec_d;
         arch_q       <= arch_d;
         inflight_q   <= inflight_d;
         ready_q      <= ready_d;
         recovering_q <= recovering_d;
         underflow_q  <= underflow_d;
      end
   end

   assign pred_ready    = ready_q;
   assign spec_hist     = spec_q;
   assign arch_hist     = arch_q;
   assign inflight      = inflight_q;
   assign recovering    = recovering_q;
   assign underflow_err = underflow_q;

`ifdef GHR_CTRL_PERF_EN
   logic stall;
   assign stall = pred_valid && !ready_q;

   ghr_perf_counters u_perf (
      .clk            (clk),
      .rst            (rst),
      .mispredict_i   (mispredict),
      .stall_i        (stall),
      .mispredict_cnt (mispredict_cnt),
      .stall_cnt      (stall_cnt)
   );
`endif

endmodule

// File: tb/tb_ghr_controller.sv
// Self-checking bench for ghr_controller: reference model feeds an expected
// queue per driven cycle; scenario tasks compare DUT snapshots against it.
module tb_ghr_controller;
   import ghr_pkg::*;

   localparam int N   = 16;
   localparam int MAX = 8;
   localparam int IW  = $clog2(MAX + 1);
   localparam int W   = 2 * N + IW + 3;

   logic          clk;
   logic          rst;
   logic          pred_valid, pred_taken, pred_ready;
   logic          res_valid, res_taken, res_mispredict;
   logic [N-1:0]  spec_hist, arch_hist;
   logic [IW-1:0] inflight;
   logic          recovering, underflow_err;
`ifdef GHR_CTRL_PERF_EN
   logic [31:0]   mispredict_cnt, stall_cnt;
`endif

   ghr_controller #(.N(N), .MAX_INFLIGHT(MAX)) dut (
      .clk            (clk),
      .rst            (rst),
      .pred_valid     (pred_valid),
      .pred_taken     (pred_taken),
      .pred_ready     (pred_ready),
      .res_valid      (res_valid),
      .res_taken      (res_taken),
      .res_mispredict (res_mispredict),
      .spec_hist      (spec_hist),
      .arch_hist      (arch_hist),
      .inflight       (inflight),
      .recovering     (recovering),
      .underflow_err  (underflow_err)
`ifdef GHR_CTRL_PERF_EN
      ,
      .mispredict_cnt (mispredict_cnt),
      .stall_cnt      (stall_cnt)
`endif
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] got, exp_v;

   // Reference model of the architectural behaviour
   logic [N-1:0] m_spec, m_arch;
   int           m_inf;
   logic         m_rec, m_und, m_ready;
   int           m_misp_cnt, m_stall_cnt;

   function automatic logic [W-1:0] snapshot();
      return {spec_hist, arch_hist, inflight, pred_ready, recovering, underflow_err};
   endfunction

   function automatic logic [W-1:0] model_snapshot();
      return {m_spec, m_arch, IW'(m_inf), m_ready, m_rec, m_und};
   endfunction

   task automatic model_reset();
      m_spec = '0; m_arch = '0; m_inf = 0;
      m_rec = 1'b0; m_und = 1'b0; m_ready = 1'b1;
      m_misp_cnt = 0; m_stall_cnt = 0;
      exp_q.delete();
   endtask

   task automatic do_reset();
      pred_valid = 0; pred_taken = 0; res_valid = 0; res_taken = 0; res_mispredict = 0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
   endtask

   // Driver: applies one cycle of stimulus, predicts its effect, returns at edge+1.
   task automatic drive(input logic pv, input logic pt, input logic rv,
                        input logic rt, input logic rm);
      logic acc, ok, misp;
      pred_valid = pv; pred_taken = pt;
      res_valid = rv; res_taken = rt; res_mispredict = rm;
      acc  = pv && m_ready;
      ok   = rv && (m_inf > 0);
      misp = ok && rm;
      if (rv && m_inf == 0) m_und = 1'b1;
      if (pv && !m_ready) m_stall_cnt++;
      if (misp) begin
         m_arch = {m_arch[N-2:0], rt};
         m_spec = m_arch;
         m_inf  = 0;
         m_rec  = 1'b1;
         m_misp_cnt++;
      end else begin
         if (ok)  m_arch = {m_arch[N-2:0], rt};
         if (acc) m_spec = {m_spec[N-2:0], pt};
         m_inf = m_inf + int'(acc) - int'(ok);
         m_rec = 1'b0;
      end
      m_ready = !m_rec && (m_inf < MAX);
      exp_q.push_back(model_snapshot());
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      exp_q.push_back({{N{1'b0}}, {N{1'b0}}, {IW{1'b0}}, 1'b1, 1'b0, 1'b0});
      got = snapshot(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin
         $display("FAIL reset_state: got %h expected %h", got, exp_v); errors++;
      end
   endtask

   task automatic test_three_preds();
      logic [2:0] dirs;
      dirs = 3'b101;
      do_reset();
      for (int i = 2; i >= 0; i--) begin
         drive(1'b1, dirs[i], 1'b0, 1'b0, 1'b0);
         got = snapshot(); exp_v = exp_q.pop_front(); checks++;
         if (got !== exp_v) begin
            $display("FAIL three_preds[%0d]: got %h expected %h", i, got, exp_v); errors++;
         end
      end
      checks++;
      if (spec_hist[2:0] !== 3'b101 || inflight !== IW'(3) || arch_hist !== '0) begin
         $display("FAIL three_preds_final: got spec=%h inflight=%0d arch=%h required spec[2:0]=101 inflight=3 arch=0",
                  spec_hist, inflight, arch_hist);
         errors++;
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < MAX + 2; i++) begin
         drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
         got = snapshot(); exp_v = exp_q.pop_front(); checks++;
         if (got !== exp_v) begin
            $display("FAIL back_to_back[%0d]: got %h expected %h", i, got, exp_v); errors++;
         end
      end
      checks++;
      if (pred_ready !== 1'b0 || inflight !== IW'(MAX)) begin
         $display("FAIL back_to_back_limit: got ready=%b inflight=%0d required ready=0 inflight=%0d",
                  pred_ready, inflight, MAX);
         errors++;
      end
`ifdef GHR_CTRL_PERF_EN
      checks++;
      if (stall_cnt !== 32'd2) begin
         $display("FAIL stall_cnt: got %0d required 2", stall_cnt); errors++;
      end
`endif
   endtask

   task automatic test_mispredict();
      do_reset();
      for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      while (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         if (exp_q.size() == 1) begin
            exp_q.push_front(exp_v);
            break;
         end
      end
      // Remaining two entries: mispredict cycle and the cycle after; only the last is live now.
      exp_v = exp_q.pop_back(); exp_q.delete();
      got = snapshot(); checks++;
      if (got !== exp_v) begin
         $display("FAIL after_recover: got %h expected %h", got, exp_v); errors++;
      end
      checks++;
      if (pred_ready !== 1'b1 || recovering !== 1'b0 || arch_hist !== 16'h0007 || spec_hist !== 16'h0007) begin
         $display("FAIL recover_exit: got ready=%b recovering=%b arch=%h spec=%h required 1 0 0007 0007",
                  pred_ready, recovering, arch_hist, spec_hist);
         errors++;
      end
   endtask

   task automatic test_mispredict_bubble();
      do_reset();
      for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      exp_q.delete();
      checks++;
      if (arch_hist !== 16'h0003 || inflight !== IW'(4)) begin
         $display("FAIL mispredict_setup: got arch=%h inflight=%0d required 0003 4", arch_hist, inflight);
         errors++;
      end
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      got = snapshot(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin
         $display("FAIL mispredict_step: got %h expected %h", got, exp_v); errors++;
      end
      checks++;
      if (arch_hist !== 16'h0007 || spec_hist !== 16'h0007 || inflight !== '0 ||
          recovering !== 1'b1 || pred_ready !== 1'b0) begin
         $display("FAIL mispredict_bubble: got arch=%h spec=%h inflight=%0d rec=%b ready=%b required 0007 0007 0 1 0",
                  arch_hist, spec_hist, inflight, recovering, pred_ready);
         errors++;
      end
   endtask

   task automatic test_resolve_and_pred();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         exp_v = exp_q.pop_front();
         if (i == 3) begin
            got = snapshot(); checks++;
            if (got !== exp_v) begin
               $display("FAIL resolve_and_pred: got %h expected %h", got, exp_v); errors++;
            end
         end
      end
      checks++;
      if (inflight !== IW'(2) || spec_hist !== 16'h003B || arch_hist !== 16'h000E) begin
         $display("FAIL resolve_and_pred_const: got inflight=%0d spec=%h arch=%h required 2 003b 000e",
                  inflight, spec_hist, arch_hist);
         errors++;
      end
   endtask

   task automatic test_mispredict_with_pred();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      got = snapshot(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin
         $display("FAIL misp_with_pred: got %h expected %h", got, exp_v); errors++;
      end
      checks++;
      if (spec_hist !== 16'h001C || arch_hist !== 16'h001C || inflight !== '0) begin
         $display("FAIL misp_with_pred_const: got spec=%h arch=%h inflight=%0d required 001c 001c 0",
                  spec_hist, arch_hist, inflight);
         errors++;
      end
   endtask

   task automatic test_underflow_and_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         got = snapshot(); exp_v = exp_q.pop_front();
         if (i == 1) begin
            checks++;
            if (got !== exp_v) begin
               $display("FAIL underflow_step: got %h expected %h", got, exp_v); errors++;
            end
         end
      end
      checks++;
      if (underflow_err !== 1'b1 || spec_hist !== 16'h001C || arch_hist !== 16'h001C) begin
         $display("FAIL underflow: got err=%b spec=%h arch=%h required 1 001c 001c",
                  underflow_err, spec_hist, arch_hist);
         errors++;
      end
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      got = snapshot(); exp_v = exp_q.pop_back(); exp_q.delete(); checks++;
      if (got !== exp_v || recovering !== 1'b1) begin
         $display("FAIL pre_reset_recover: got %h expected %h", got, exp_v); errors++;
      end
      // Asynchronous reset while the bubble is active, well away from an edge.
      rst = 1'b1;
      #1;
      got = snapshot(); checks++;
      if (got !== {{N{1'b0}}, {N{1'b0}}, {IW{1'b0}}, 1'b1, 1'b0, 1'b0}) begin
         $display("FAIL mid_recover_reset: got %h required reset values", got); errors++;
      end
`ifdef GHR_CTRL_PERF_EN
      checks++;
      if (mispredict_cnt !== '0 || stall_cnt !== '0) begin
         $display("FAIL perf_reset: got misp=%0d stall=%0d required 0 0", mispredict_cnt, stall_cnt);
         errors++;
      end
`endif
      #1 rst = 1'b0;
      model_reset();
   endtask

   initial begin
      rst = 1'b1;
      test_reset();
      test_three_preds();
      test_back_to_back();
      test_mispredict();
      test_mispredict_bubble();
      test_resolve_and_pred();
      test_mispredict_with_pred();
      test_underflow_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ghr_controller.md
# ghr_controller

Speculative global-history manager for the perceptron predictor. Keeps two N-bit branch histories: a speculative history, updated when a prediction is issued, and an architectural history, updated when a branch resolves. It throttles prediction issue to a bounded number of unresolved branches. On a mispredict it restores the speculative history from the architectural one and inserts a one-cycle recovery bubble. It sits between the fetch-side predictor (which indexes perceptrons with `spec_hist`) and the resolve/training path (which uses `arch_hist`).

## Interface
- `N`, default `` `NUM_PERCEPTRONS ``: history length in bits.
- `MAX_INFLIGHT`, default 8: maximum number of unresolved predictions (≥1).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `pred_valid`  in  1  predictor issues a prediction this cycle.
- `pred_taken`  in  1  predicted direction.
- `pred_ready`  out  1  prediction accepted when `pred_valid && pred_ready`.
- `res_valid`  in  1  the oldest in-flight branch resolves this cycle.
- `res_taken`  in  1  actual direction.
- `res_mispredict`  in  1  the resolved branch was mispredicted (qualified by `res_valid`).
- `spec_hist`  out  N  speculative history; bit 0 is the newest.
- `arch_hist`  out  N  committed history; bit 0 is the newest.
- `inflight`  out  $clog2(MAX_INFLIGHT+1)  count of unresolved accepted predictions.
- `recovering`  out  1  high during the recovery bubble.
- `underflow_err`  out  1  sticky; set when a resolve arrives with `inflight==0`.

## Operation
- Shift rule for both histories: `h <= {h[N-2:0], bit}`. The new bit enters at [0]; bit [N-1] is discarded.
- FSM states are RUN and RECOVER. Reset enters RUN.
- `pred_ready = (state==RUN) && (inflight < MAX_INFLIGHT)`. It is decoded from registers only, with no combinational path from inputs.
- Accepted prediction:
  - `spec_hist` shifts in `pred_taken`.
  - `inflight` increments by 1.
- Correct resolve (`res_valid && !res_mispredict && inflight>0`):
  - `arch_hist` shifts in `res_taken`.
  - `inflight` decrements by 1.
- Correct resolve and accepted prediction in the same cycle:
  - Both histories shift.
  - `inflight` is unchanged.
  - This is legal when `inflight==MAX_INFLIGHT` only if `pred_ready` was high, which it is not. At the limit the prediction is therefore not accepted.
- Mispredict (`res_valid && res_mispredict && inflight>0`):
  - `arch_hist` shifts in `res_taken`.
  - `spec_hist` is loaded with the same new `arch_hist` value.
  - `inflight` is set to 0, since all younger branches are squashed.
  - The FSM goes to RECOVER.
- Mispredict wins over a same-cycle accepted prediction. That prediction does not touch `spec_hist` or `inflight`, and upstream must squash it.
- RECOVER lasts exactly 1 cycle:
  - `pred_ready=0` and `recovering=1`.
  - The FSM then returns to RUN unconditionally.
- Resolve with `inflight==0`, in any state:
  - Both histories and `inflight` are unchanged.
  - `underflow_err` is set; it clears only on `rst`.
- `rst` asserted at any time, including mid-RECOVER: all state is immediately cleared.

## Timing
- All outputs are registered. Every update is visible the cycle after the triggering edge.
- Mispredict at edge k:
  - Restored `spec_hist` is valid after k.
  - `pred_ready=0` during cycle k+1.
  - `pred_ready` is high again from k+2, provided `inflight<MAX_INFLIGHT`.
- Prediction-to-`spec_hist` latency is 1 cycle, so back-to-back predictions see the updated history each cycle.
- Reset values:
  - `spec_hist=0`, `arch_hist=0`, `inflight=0`.
  - `recovering=0`, `underflow_err=0`.
  - `pred_ready=1` (the FSM is in RUN).

## Configuration
- Macro: `GHR_CTRL_PERF_EN`.
- When defined, two extra outputs are added:
  - `mispredict_cnt` (32 bits): increments on each accepted mispredict.
  - `stall_cnt` (32 bits): increments each cycle with `pred_valid && !pred_ready`.
  - Both counters wrap at 2^32 and reset to 0.
- When undefined, these ports and counters do not exist, and the rest of the behaviour is identical.

## Structure
- Package `ghr_pkg` holds:
  - the FSM state enum `ghr_state_t` (RUN, RECOVER);
  - the `inflight` width constant derived from `MAX_INFLIGHT`;
  - the performance-counter width constant (32).
- One sub-module, `ghr_perf_counters`, holds both counters. It is instantiated only under `GHR_CTRL_PERF_EN`.

## Test plan
- Reset, then 3 accepted predictions T,N,T → `spec_hist[2:0]=3'b101`, `inflight=3`, `arch_hist=0`.
- 8 back-to-back predictions with `MAX_INFLIGHT=8`:
  - `pred_ready` drops after the 8th.
  - A held 9th `pred_valid` is not accepted.
  - `stall_cnt` increments each stalled cycle, with the macro on.
- With `arch_hist=...0011` and `inflight=4`, a resolve taken with mispredict arrives:
  - Next cycle `arch_hist=spec_hist=...0111`, `inflight=0`, `recovering=1`, `pred_ready=0`.
  - `pred_ready=1` on the following cycle.
- Correct resolve and prediction in the same cycle at `inflight=2` → `inflight` stays 2, and both histories shift by 1.
- Mispredict with a same-cycle `pred_valid` → the prediction bit is absent from `spec_hist`.
- `res_valid` at `inflight=0` → histories unchanged and `underflow_err=1`. Then `rst` is asserted mid-RECOVER → all outputs return to reset values.
